// File: rtl/mem_arbiter.sv
// mem_arbiter: three-client memory arbiter (Icache fill, Dcache fill, Dcache
// writeback) in front of a single-ported memory with a req/ack handshake.
// One transaction is outstanding at a time: IDLE -> MEM -> RESP -> IDLE.
module mem_arbiter #(
    parameter int WIDTH  = 128,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ic_read_req,
    input  logic [ADDR_W-1:0] ic_read_addr,
    output logic              ic_read_ack,
    output logic [WIDTH-1:0]  ic_read_data,

    input  logic              dc_read_req,
    input  logic [ADDR_W-1:0] dc_read_addr,
    output logic              dc_read_ack,
    output logic [WIDTH-1:0]  dc_read_data,

    input  logic              dc_write_req,
    input  logic [ADDR_W-1:0] dc_write_addr,
    input  logic [WIDTH-1:0]  dc_write_data,
    output logic              dc_write_ack,

    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_data_out,
    input  logic [WIDTH-1:0]  mem_data_in,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        C_IC_RD,
        C_DC_RD,
        C_DC_WR
    } client_e;

    state_e              state_q,        state_d;
    client_e             client_q,       client_d;
    logic                last_dc_q,      last_dc_d;      // 1: Dcache was granted last
    logic                mem_enable_q,   mem_enable_d;
    logic                mem_rw_q,       mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q,     mem_addr_d;
    logic [WIDTH-1:0]    mem_wdata_q,    mem_wdata_d;
    logic [WIDTH-1:0]    rd_data_q,      rd_data_d;
    logic                ic_rd_ack_q,    ic_rd_ack_d;
    logic                dc_rd_ack_q,    dc_rd_ack_d;
    logic                dc_wr_ack_q,    dc_wr_ack_d;

    logic                ic_req;
    logic                dc_req;
    logic                pick_dc;

    // Arbitration: on an Icache/Dcache tie the side not granted last wins.
    always_comb begin
        ic_req  = ic_read_req;
        dc_req  = dc_write_req | dc_read_req;
        pick_dc = dc_req && (!ic_req || !last_dc_q);
    end

    // Next-state and next-output computation for the IDLE/MEM/RESP sequence.
    always_comb begin
        // NOTE: every variable gets a default here so no path can leave one
        // unassigned and infer a latch; the defaults also mean "hold".
        state_d      = state_q;
        client_d     = client_q;
        last_dc_d    = last_dc_q;
        mem_enable_d = mem_enable_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rd_data_d    = rd_data_q;
        ic_rd_ack_d  = 1'b0;
        dc_rd_ack_d  = 1'b0;
        dc_wr_ack_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ic_req || dc_req) begin
                    state_d      = S_MEM;
                    mem_enable_d = 1'b1;
                    last_dc_d    = pick_dc;
                    if (pick_dc && dc_write_req) begin
                        client_d    = C_DC_WR;
                        mem_rw_d    = 1'b1;
                        mem_addr_d  = dc_write_addr;
                        mem_wdata_d = dc_write_data;
                    end else if (pick_dc) begin
                        client_d    = C_DC_RD;
                        mem_rw_d    = 1'b0;
                        mem_addr_d  = dc_read_addr;
                        mem_wdata_d = '0;
                    end else begin
                        client_d    = C_IC_RD;
                        mem_rw_d    = 1'b0;
                        mem_addr_d  = ic_read_addr;
                        mem_wdata_d = '0;
                    end
                end
            end

            S_MEM: begin
                // Requests are not re-sampled here; a dropped req does not abort.
                if (mem_ack) begin
                    state_d      = S_RESP;
                    mem_enable_d = 1'b0;
                    mem_rw_d     = 1'b0;
                    mem_wdata_d  = '0;
                    if (!mem_rw_q) begin
                        rd_data_d = mem_data_in;
                    end
                    case (client_q)
                        C_IC_RD: ic_rd_ack_d = 1'b1;
                        C_DC_RD: dc_rd_ack_d = 1'b1;
                        C_DC_WR: dc_wr_ack_d = 1'b1;
                        default: ;
                    endcase
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset abandons any transaction.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= S_IDLE;
            client_q     <= C_IC_RD;
            last_dc_q    <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_data_q    <= '0;
            ic_rd_ack_q  <= 1'b0;
            dc_rd_ack_q  <= 1'b0;
            dc_wr_ack_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            client_q     <= client_d;
            last_dc_q    <= last_dc_d;
            mem_enable_q <= mem_enable_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_data_q    <= rd_data_d;
            ic_rd_ack_q  <= ic_rd_ack_d;
            dc_rd_ack_q  <= dc_rd_ack_d;
            dc_wr_ack_q  <= dc_wr_ack_d;
        end
    end

    assign mem_enable   = mem_enable_q;
    assign mem_rw       = mem_rw_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_out = mem_wdata_q;
    assign ic_read_ack  = ic_rd_ack_q;
    assign dc_read_ack  = dc_rd_ack_q;
    assign dc_write_ack = dc_wr_ack_q;
    // Both read-data ports share the one latched register; the ack qualifies it.
    assign ic_read_data = rd_data_q;
    assign dc_read_data = rd_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with hand-computed
// expectations; inputs are driven and outputs sampled on the falling edge.
module tb_mem_arbiter;

    localparam int WIDTH  = 128;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_read_req;
    logic [ADDR_W-1:0] ic_read_addr;
    logic              ic_read_ack;
    logic [WIDTH-1:0]  ic_read_data;
    logic              dc_read_req;
    logic [ADDR_W-1:0] dc_read_addr;
    logic              dc_read_ack;
    logic [WIDTH-1:0]  dc_read_data;
    logic              dc_write_req;
    logic [ADDR_W-1:0] dc_write_addr;
    logic [WIDTH-1:0]  dc_write_data;
    logic              dc_write_ack;
    logic              mem_enable;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_data_out;
    logic [WIDTH-1:0]  mem_data_in;
    logic              mem_ack;

    int n_total = 0;
    int n_pass  = 0;
    int inv_err = 0;

    mem_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .ic_read_req  (ic_read_req),
        .ic_read_addr (ic_read_addr),
        .ic_read_ack  (ic_read_ack),
        .ic_read_data (ic_read_data),
        .dc_read_req  (dc_read_req),
        .dc_read_addr (dc_read_addr),
        .dc_read_ack  (dc_read_ack),
        .dc_read_data (dc_read_data),
        .dc_write_req (dc_write_req),
        .dc_write_addr(dc_write_addr),
        .dc_write_data(dc_write_data),
        .dc_write_ack (dc_write_ack),
        .mem_enable   (mem_enable),
        .mem_rw       (mem_rw),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_ack      (mem_ack)
    );

    always #5 clk = ~clk;

    // Invariant monitor: at most one ack, and never an ack while memory is busy.
    always @(negedge clk) begin
        if (!$onehot0({ic_read_ack, dc_read_ack, dc_write_ack}) ||
            ((ic_read_ack | dc_read_ack | dc_write_ack) && mem_enable)) begin
            inv_err++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Memory model: waits for mem_enable, checks the request holds for
    // 'cycles' cycles, pulses mem_ack in the last one; returns at the RESP cycle.
    task automatic serve(input int cycles, input logic [WIDTH-1:0] rdata,
                         input logic [ADDR_W-1:0] exp_addr, input logic exp_rw,
                         input logic [WIDTH-1:0] exp_wd, input string tag);
        int waited = 0;
        bit stable = 1'b1;
        logic [ADDR_W-1:0] bad_addr = '0;
        logic              bad_en   = 1'b0;
        logic              bad_rw   = 1'b0;
        logic [WIDTH-1:0]  bad_wd   = '0;
        while (mem_enable !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_total++;
        if (mem_enable !== 1'b1) begin
            $display("FAIL %s_start: mem_enable=%b after %0d cycles, want 1", tag, mem_enable, waited);
            return;
        end else n_pass++;
        for (int i = 0; i < cycles; i++) begin
            if (stable && (mem_enable !== 1'b1 || mem_addr !== exp_addr ||
                           mem_rw !== exp_rw || mem_data_out !== exp_wd)) begin
                stable   = 1'b0;
                bad_en   = mem_enable;
                bad_addr = mem_addr;
                bad_rw   = mem_rw;
                bad_wd   = mem_data_out;
            end
            if (i == cycles - 1) begin
                mem_ack     = 1'b1;
                mem_data_in = rdata;
            end
            @(negedge clk);
        end
        mem_ack     = 1'b0;
        mem_data_in = '0;
        n_total++;
        if (!stable)
            $display("FAIL %s_hold: got en=%b addr=%h rw=%b wd=%h, want en=1 addr=%h rw=%b wd=%h",
                     tag, bad_en, bad_addr, bad_rw, bad_wd, exp_addr, exp_rw, exp_wd);
        else n_pass++;
        n_total++;
        if (mem_enable !== 1'b0) $display("FAIL %s_en_drop: got %b want 0", tag, mem_enable);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (mem_enable !== 1'b0) $display("FAIL rst_en: got %b want 0", mem_enable); else n_pass++;
        n_total++; if (mem_rw !== 1'b0) $display("FAIL rst_rw: got %b want 0", mem_rw); else n_pass++;
        n_total++; if (mem_addr !== '0) $display("FAIL rst_addr: got %h want 0", mem_addr); else n_pass++;
        n_total++; if (mem_data_out !== '0) $display("FAIL rst_wd: got %h want 0", mem_data_out); else n_pass++;
        n_total++;
        if ({ic_read_ack, dc_read_ack, dc_write_ack} !== 3'b000)
            $display("FAIL rst_acks: got %b want 000", {ic_read_ack, dc_read_ack, dc_write_ack});
        else n_pass++;
        n_total++; if (ic_read_data !== '0) $display("FAIL rst_rdata: got %h want 0", ic_read_data); else n_pass++;
    endtask

    task automatic test_icache_only();
        logic [WIDTH-1:0] d = {16{8'hA5}};
        ic_read_req  = 1'b1;
        ic_read_addr = 32'h0000_0040;
        serve(3, d, 32'h40, 1'b0, '0, "ic_only");
        n_total++;
        if ({ic_read_ack, dc_read_ack, dc_write_ack} !== 3'b100)
            $display("FAIL ic_only_ack: got %b want 100", {ic_read_ack, dc_read_ack, dc_write_ack});
        else n_pass++;
        n_total++; if (ic_read_data !== d) $display("FAIL ic_only_data: got %h want %h", ic_read_data, d); else n_pass++;
        n_total++; if (dc_read_data !== d) $display("FAIL ic_only_shared: got %h want %h", dc_read_data, d); else n_pass++;
        ic_read_req = 1'b0;
        @(negedge clk);
        n_total++; if (ic_read_ack !== 1'b0) $display("FAIL ic_only_pulse: got %b want 0", ic_read_ack); else n_pass++;
    endtask

    task automatic test_tie();
        logic [WIDTH-1:0] d1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        logic [WIDTH-1:0] d2 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
        do_reset();
        ic_read_req  = 1'b1;  ic_read_addr = 32'h100;
        dc_read_req  = 1'b1;  dc_read_addr = 32'h200;
        serve(2, d1, 32'h200, 1'b0, '0, "tie_dc");
        n_total++;
        if ({ic_read_ack, dc_read_ack, dc_write_ack} !== 3'b010)
            $display("FAIL tie_dc_ack: got %b want 010", {ic_read_ack, dc_read_ack, dc_write_ack});
        else n_pass++;
        n_total++; if (dc_read_data !== d1) $display("FAIL tie_dc_data: got %h want %h", dc_read_data, d1); else n_pass++;
        dc_read_req = 1'b0;
        serve(1, d2, 32'h100, 1'b0, '0, "tie_ic");
        n_total++;
        if ({ic_read_ack, dc_read_ack, dc_write_ack} !== 3'b100)
            $display("FAIL tie_ic_ack: got %b want 100", {ic_read_ack, dc_read_ack, dc_write_ack});
        else n_pass++;
        n_total++; if (ic_read_data !== d2) $display("FAIL tie_ic_data: got %h want %h", ic_read_data, d2); else n_pass++;
        ic_read_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_priority();
        logic [WIDTH-1:0] d = 128'hCAFE;
        dc_write_req  = 1'b1; dc_write_addr = 32'h300; dc_write_data = 128'h1234;
        dc_read_req   = 1'b1; dc_read_addr  = 32'h400;
        serve(2, 128'hBAD, 32'h300, 1'b1, 128'h1234, "wr_first");
        n_total++;
        if ({ic_read_ack, dc_read_ack, dc_write_ack} !== 3'b001)
            $display("FAIL wr_ack: got %b want 001", {ic_read_ack, dc_read_ack, dc_write_ack});
        else n_pass++;
        n_total++; if (mem_data_out !== '0) $display("FAIL wr_data_clear: got %h want 0", mem_data_out); else n_pass++;
        n_total++; if (dc_read_data !== 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000)
            $display("FAIL wr_keeps_rdata: got %h want 9999aaaabbbbccccddddeeeeffff0000", dc_read_data); else n_pass++;
        dc_write_req = 1'b0;
        serve(1, d, 32'h400, 1'b0, '0, "rd_second");
        n_total++;
        if ({ic_read_ack, dc_read_ack, dc_write_ack} !== 3'b010)
            $display("FAIL rd2_ack: got %b want 010", {ic_read_ack, dc_read_ack, dc_write_ack});
        else n_pass++;
        n_total++; if (dc_read_data !== d) $display("FAIL rd2_data: got %h want %h", dc_read_data, d); else n_pass++;
        dc_read_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] f1 = 128'hF1;
        logic [WIDTH-1:0] f2 = 128'hF2;
        do_reset();
        ic_read_req  = 1'b1; ic_read_addr  = 32'h600;
        dc_write_req = 1'b1; dc_write_addr = 32'h700; dc_write_data = 128'h77;
        dc_read_req  = 1'b1; dc_read_addr  = 32'h800;
        for (int t = 0; t < 2; t++) begin
            serve(1, 128'h0, 32'h700, 1'b1, 128'h77, "b2b_dc");
            n_total++;
            if ({ic_read_ack, dc_read_ack, dc_write_ack} !== 3'b001)
                $display("FAIL b2b_dc_ack%0d: got %b want 001", t, {ic_read_ack, dc_read_ack, dc_write_ack});
            else n_pass++;
            serve(1, (t == 0) ? f1 : f2, 32'h600, 1'b0, '0, "b2b_ic");
            n_total++;
            if ({ic_read_ack, dc_read_ack, dc_write_ack} !== 3'b100)
                $display("FAIL b2b_ic_ack%0d: got %b want 100", t, {ic_read_ack, dc_read_ack, dc_write_ack});
            else n_pass++;
            n_total++;
            if (ic_read_data !== ((t == 0) ? f1 : f2))
                $display("FAIL b2b_ic_data%0d: got %h want %h", t, ic_read_data, (t == 0) ? f1 : f2);
            else n_pass++;
        end
        ic_read_req = 1'b0; dc_write_req = 1'b0; dc_read_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        dc_read_req = 1'b1; dc_read_addr = 32'h500;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (mem_enable !== 1'b1 || mem_addr !== 32'h500)
            $display("FAIL rmid_inflight: got en=%b addr=%h want en=1 addr=00000500", mem_enable, mem_addr);
        else n_pass++;
        reset = 1'b1; dc_read_req = 1'b0;
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1; mem_data_in = 128'hDEAD;
        n_total++; if (mem_enable !== 1'b0) $display("FAIL rmid_en: got %b want 0", mem_enable); else n_pass++;
        n_total++; if (mem_addr !== '0) $display("FAIL rmid_addr: got %h want 0", mem_addr); else n_pass++;
        @(negedge clk);
        mem_ack = 1'b0; mem_data_in = '0;
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if ({ic_read_ack, dc_read_ack, dc_write_ack, mem_enable} !== 4'b0000)
                $display("FAIL rmid_noack%0d: got acks/en=%b want 0000", i, {ic_read_ack, dc_read_ack, dc_write_ack, mem_enable});
            else n_pass++;
            @(negedge clk);
        end
        n_total++; if (dc_read_data !== '0) $display("FAIL rmid_rdata: got %h want 0", dc_read_data); else n_pass++;
    endtask

    task automatic test_spurious_ack();
        mem_ack = 1'b1; mem_data_in = 128'hFEED;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b0; mem_data_in = '0;
        n_total++;
        if ({ic_read_ack, dc_read_ack, dc_write_ack, mem_enable} !== 4'b0000)
            $display("FAIL spur_out: got acks/en=%b want 0000", {ic_read_ack, dc_read_ack, dc_write_ack, mem_enable});
        else n_pass++;
        n_total++; if (ic_read_data !== '0) $display("FAIL spur_rdata: got %h want 0", ic_read_data); else n_pass++;
    endtask

    task automatic test_drop_during_mem();
        logic [WIDTH-1:0] d = 128'h0DD;
        ic_read_req = 1'b1; ic_read_addr = 32'h900;
        @(negedge clk);
        ic_read_req = 1'b0;
        serve(2, d, 32'h900, 1'b0, '0, "drop");
        n_total++;
        if ({ic_read_ack, dc_read_ack, dc_write_ack} !== 3'b100)
            $display("FAIL drop_ack: got %b want 100", {ic_read_ack, dc_read_ack, dc_write_ack});
        else n_pass++;
        n_total++; if (ic_read_data !== d) $display("FAIL drop_data: got %h want %h", ic_read_data, d); else n_pass++;
        @(negedge clk);
        n_total++;
        if ({ic_read_ack, mem_enable} !== 2'b00)
            $display("FAIL drop_idle: got ack/en=%b want 00", {ic_read_ack, mem_enable});
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        ic_read_req = 1'b0;  ic_read_addr = '0;
        dc_read_req = 1'b0;  dc_read_addr = '0;
        dc_write_req = 1'b0; dc_write_addr = '0; dc_write_data = '0;
        mem_data_in = '0;    mem_ack = 1'b0;
        @(negedge clk);

        test_reset();
        test_icache_only();
        test_tie();
        test_write_priority();
        test_back_to_back();
        test_reset_mid();
        test_spurious_ack();
        test_drop_during_mem();

        n_total++;
        if (inv_err !== 0) $display("FAIL ack_invariant: got %0d violations want 0", inv_err);
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
